// File: rtl/ofm_quant_pack.sv
// ofm_quant_pack: quantizes the two CONV_ACC partial-sum lanes to int8 using
// optional ReLU, a rounding arithmetic shift and saturation. It packs the
// bytes into 64-bit words and buffers them in a FIFO toward the memory
// writer. An end_op pulse flushes the layer and tags its final word with
// out_last.
module ofm_quant_pack #(
   parameter int IN_W       = 25,
   parameter int FIFO_DEPTH = 16,
   parameter int FIFO_AW    = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [IN_W-1:0] ofm_port0,
   input  logic [IN_W-1:0] ofm_port1,
   input  logic            ofm_port0_v,
   input  logic            ofm_port1_v,
   input  logic            end_op,
   input  logic [4:0]      cfg_shift,
   input  logic            cfg_relu,
   output logic [63:0]     out_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_last,
   output logic            overflow,
   output logic            done
);

   typedef enum logic [1:0] {RUN, FL_STG, FL_PART, DRAIN} state_t;

   localparam logic signed [IN_W:0] SAT_HI = (IN_W+1)'(127);
   localparam logic signed [IN_W:0] SAT_LO = (IN_W+1)'(-128);

   state_t state, state_nxt;

   logic [63:0] acc, acc_nxt;
   logic [2:0]  bcnt, bcnt_nxt;
   logic [63:0] stg, stg_nxt;
   logic        stg_v, stg_v_nxt;
   logic        done_nxt;

   logic        push_req;
   logic [63:0] push_word;
   logic        push_last;
   logic        push, pop, can_push, full, empty;

   logic [64:0]        mem [0:FIFO_DEPTH-1];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   count;
   logic [64:0]        head;

   logic [7:0]  q0, q1, first_b;
   logic [1:0]  nb;
   logic [3:0]  new_cnt;
   logic [7:0]  ext_b [0:8];
   logic [63:0] pk_word, pk_acc;
   logic [2:0]  pk_cnt;
   logic        pk_done;

   // ReLU, rounding arithmetic right shift, then saturation to int8
   function automatic logic [7:0] quant(input logic [IN_W-1:0] x,
                                        input logic [4:0] sh,
                                        input logic relu);
      logic signed [IN_W:0] v;
      logic signed [IN_W:0] rnd;
      v = {x[IN_W-1], x};
      if (relu && v[IN_W]) v = '0;
      rnd = '0;
      if (sh != 5'd0) rnd = (IN_W+1)'(1) << (sh - 5'd1);
      v = v + rnd;
      v = v >>> sh;
      if (v > SAT_HI)      quant = 8'h7F;
      else if (v < SAT_LO) quant = 8'h80;
      else                 quant = v[7:0];
   endfunction

   assign q0      = quant(ofm_port0, cfg_shift, cfg_relu);
   assign q1      = quant(ofm_port1, cfg_shift, cfg_relu);
   assign first_b = ofm_port0_v ? q0 : q1;
   assign nb      = {1'b0, ofm_port0_v} + {1'b0, ofm_port1_v};
   assign new_cnt = {1'b0, bcnt} + {2'b00, nb};

   // Append this cycle's bytes to the accumulator in a 9-byte scratch so a
   // ninth byte (2 bytes arriving at bcnt=7) carries into the next word
   always_comb begin
      for (int unsigned k = 0; k < 8; k++) begin
         ext_b[k] = (k < 32'(bcnt)) ? acc[8*k +: 8] : 8'h00;
      end
      ext_b[8] = 8'h00;
      for (int unsigned k = 0; k < 9; k++) begin
         if (nb != 2'd0 && k == 32'(bcnt))         ext_b[k] = first_b;
         if (nb == 2'd2 && k == 32'(bcnt) + 32'd1) ext_b[k] = q1;
      end
      pk_word = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         pk_word[8*k +: 8] = ext_b[k];
      end
      pk_done = new_cnt[3];
      pk_cnt  = new_cnt[2:0];
      pk_acc  = pk_done ? {56'h0, ext_b[8]} : pk_word;
   end

   assign empty    = (count == '0);
   assign full     = (count == (FIFO_AW+1)'(FIFO_DEPTH));
   assign pop      = !empty && out_ready;
   assign can_push = !full || pop;
   assign push     = push_req && can_push;

   // FSM next-state, packer/stage update and FIFO push request
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      bcnt_nxt  = bcnt;
      stg_nxt   = stg;
      stg_v_nxt = stg_v;
      push_req  = 1'b0;
      push_word = stg;
      push_last = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         RUN: begin
            acc_nxt  = pk_acc;
            bcnt_nxt = pk_cnt;
            if (pk_done) begin
               push_req  = stg_v;
               stg_nxt   = pk_word;
               stg_v_nxt = 1'b1;
            end
            if (end_op) state_nxt = FL_STG;
         end
         FL_STG: begin
            if (stg_v) begin
               if (can_push) begin
                  push_req  = 1'b1;
                  push_last = (bcnt == 3'd0);
                  stg_v_nxt = 1'b0;
                  state_nxt = (bcnt != 3'd0) ? FL_PART : DRAIN;
               end
            end else if (bcnt != 3'd0) begin
               state_nxt = FL_PART;
            end else begin
               done_nxt  = 1'b1;
               state_nxt = RUN;
            end
         end
         FL_PART: begin
            if (can_push) begin
               push_req  = 1'b1;
               push_word = acc;
               push_last = 1'b1;
               acc_nxt   = '0;
               bcnt_nxt  = '0;
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && head[64]) begin
               done_nxt  = 1'b1;
               state_nxt = RUN;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   // Packer, staged slot, sticky overflow and done pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         bcnt     <= '0;
         stg      <= '0;
         stg_v    <= 1'b0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         acc   <= acc_nxt;
         bcnt  <= bcnt_nxt;
         stg   <= stg_nxt;
         stg_v <= stg_v_nxt;
         done  <= done_nxt;
         if (push_req && !can_push) overflow <= 1'b1;
      end
   end

   // FIFO storage; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {push_last, push_word};
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (FIFO_AW+1)'(1);
            2'b01:   count <= count - (FIFO_AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign head      = mem[rd_ptr];
   assign out_valid = !empty;
   assign out_data  = empty ? 64'h0 : head[63:0];
   assign out_last  = !empty && head[64];

endmodule

// File: tb/tb_ofm_quant_pack.sv
// Self-checking bench for ofm_quant_pack: expected words are queued as
// stimulus is driven and compared as they handshake out of the DUT.
module tb_ofm_quant_pack;
   localparam int IN_W  = 25;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [IN_W-1:0] ofm_port0, ofm_port1;
   logic            ofm_port0_v, ofm_port1_v, end_op;
   logic [4:0]      cfg_shift;
   logic            cfg_relu;
   logic [63:0]     out_data;
   logic            out_valid, out_ready, out_last, overflow, done;

   int          checks = 0;
   int          failures = 0;
   int          hs_cnt = 0;
   bit          model_on = 0;
   bit          rand_rdy = 0;
   logic [64:0] exp_q[$];
   logic [7:0]  byte_q[$];

   always #5 clk = ~clk;

   ofm_quant_pack #(.IN_W(IN_W), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
      .clk(clk), .rst(rst),
      .ofm_port0(ofm_port0), .ofm_port1(ofm_port1),
      .ofm_port0_v(ofm_port0_v), .ofm_port1_v(ofm_port1_v),
      .end_op(end_op), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .overflow(overflow), .done(done)
   );

   task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ref_q(input int x, input int sh, input bit relu);
      longint v;
      v = x;
      if (relu && v < 0) v = 0;
      if (sh > 0) v = v + (longint'(1) << (sh - 1));
      v = v >>> sh;
      if (v > 127)  return 8'h7F;
      if (v < -128) return 8'h80;
      return 8'(v);
   endfunction

   task automatic take_word(input bit last);
      logic [63:0] w;
      w = '0;
      for (int k = 0; k < 8; k++)
         if (byte_q.size() > 0) w[8*k +: 8] = byte_q.pop_front();
      exp_q.push_back({last, w});
   endtask

   task automatic flush_model();
      if (byte_q.size() > 8) take_word(1'b0);
      if (byte_q.size() > 0) take_word(1'b1);
   endtask

   // Handshake monitor: every accepted word must match the scoreboard head
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         hs_cnt++;
         check("word_expected", 65'(exp_q.size() != 0), 65'd1);
         if (exp_q.size() != 0) check("out_word", {out_last, out_data}, exp_q.pop_front());
      end
   end

   task automatic cyc(input bit v0, input int x0, input bit v1, input int x1);
      ofm_port0   = IN_W'(x0);
      ofm_port1   = IN_W'(x1);
      ofm_port0_v = v0;
      ofm_port1_v = v1;
      if (model_on) begin
         if (v0) byte_q.push_back(ref_q(x0, int'(cfg_shift), cfg_relu));
         if (v1) byte_q.push_back(ref_q(x1, int'(cfg_shift), cfg_relu));
      end
      @(posedge clk);
      #1;
      ofm_port0_v = 1'b0;
      ofm_port1_v = 1'b0;
      if (rand_rdy) out_ready = 1'($urandom);
      if (model_on) while (byte_q.size() >= 16) take_word(1'b0);
   endtask

   task automatic wait_done(input int budget);
      bit got;
      got = 0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (done) got = 1;
         else begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom);
         end
      end
      check("done", 65'(got), 65'd1);
      if (got) begin
         @(negedge clk);
         check("done_pulse", 65'(done), 65'd0);
      end
      check("sb_drained", 65'(exp_q.size()), 65'd0);
      out_ready = 1'b1;
   endtask

   task automatic end_layer(input int budget);
      if (model_on) flush_model();
      end_op = 1'b1;
      @(posedge clk);
      #1;
      end_op = 1'b0;
      wait_done(budget);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

   initial begin
      logic [63:0] w;
      int x0, x1;
      rst = 1'b1; ofm_port0 = '0; ofm_port1 = '0; ofm_port0_v = 0; ofm_port1_v = 0;
      end_op = 0; cfg_shift = 5'd0; cfg_relu = 0; out_ready = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 65'(out_valid), 65'd0);
      check("rst_last", 65'(out_last), 65'd0);
      check("rst_data", 65'(out_data), 65'd0);
      check("rst_overflow", 65'(overflow), 65'd0);
      check("rst_done", 65'(done), 65'd0);
      @(posedge clk); #1; rst = 1'b0; out_ready = 1'b1;

      // Quantize with shift 4: 200->0x0D, -1000->0xC2, 2047->sat 0x7F, 8->0x01
      cfg_shift = 5'd4; cfg_relu = 0;
      exp_q.push_back({1'b1, 64'h00000000_017FC20D});
      cyc(1, 200, 0, 0); cyc(1, -1000, 0, 0); cyc(1, 2047, 0, 0); cyc(1, 8, 0, 0);
      repeat (4) cyc(1, 0, 0, 0);
      end_layer(50);

      // ReLU with shift 0, partial word padded
      cfg_shift = 5'd0; cfg_relu = 1;
      exp_q.push_back({1'b1, 64'h00000000_007F7F00});
      cyc(1, -5, 0, 0); cyc(1, 127, 0, 0); cyc(1, 300, 0, 0);
      end_layer(50);

      // Flush with no data still pulses done
      cfg_relu = 0;
      end_layer(20);

      // Dual-lane packing, two full words, no padding word
      model_on = 1;
      for (int i = 0; i < 8; i++) cyc(1, 2*i + 1, 1, 2*i + 2);
      end_layer(50);

      // Odd carry: lane 1 alone, then 4 dual cycles
      cyc(0, 0, 1, 1);
      for (int i = 0; i < 4; i++) cyc(1, 2 + 2*i, 1, 3 + 2*i);
      end_layer(50);

      // Randomized layers with random backpressure
      rand_rdy = 1;
      for (int l = 0; l < 4; l++) begin
         cfg_shift = 5'($urandom_range(24, 0));
         cfg_relu  = 1'($urandom);
         for (int c = 0; c < 12; c++) begin
            if ($urandom_range(1, 0) == 1) begin
               x0 = int'($urandom_range(33554431, 0)) - 16777216;
               x1 = int'($urandom_range(33554431, 0)) - 16777216;
            end else begin
               x0 = int'($urandom_range(4095, 0)) - 2048;
               x1 = int'($urandom_range(4095, 0)) - 2048;
            end
            cyc(1'($urandom), x0, 1'($urandom), x1);
         end
         end_layer(300);
      end
      rand_rdy = 0; out_ready = 1'b1;

      // Backpressure: 18 words into a 16-deep FIFO; word 16 is dropped
      model_on = 0; cfg_shift = 5'd0; cfg_relu = 0; out_ready = 1'b0;
      for (int j = 0; j < 18; j++) begin
         if (j != 16) begin
            for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'((8*j + k) % 128);
            exp_q.push_back({(j == 17), w});
         end
      end
      for (int c = 0; c < 72; c++) cyc(1, (2*c) % 128, 1, (2*c + 1) % 128);
      @(negedge clk);
      check("overflow_set", 65'(overflow), 65'd1);
      check("hold_valid", 65'(out_valid), 65'd1);
      check("hold_head", {out_last, out_data}, exp_q[0]);
      end_op = 1'b1; @(posedge clk); #1; end_op = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("hold_head_later", {out_last, out_data}, exp_q[0]);
      @(posedge clk); #1; out_ready = 1'b1;
      wait_done(200);
      check("overflow_sticky", 65'(overflow), 65'd1);

      // Reset mid-operation with 3 words buffered and one staged
      out_ready = 1'b0;
      for (int c = 0; c < 16; c++) cyc(1, 2*c + 1, 1, 2*c + 2);
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("midrst_valid", 65'(out_valid), 65'd0);
      check("midrst_overflow", 65'(overflow), 65'd0);
      @(posedge clk); #1;
      model_on = 1; byte_q.delete(); hs_cnt = 0; out_ready = 1'b1;
      for (int c = 0; c < 8; c++) cyc(1, 10 + c, 0, 0);
      end_layer(50);
      check("one_word", 65'(hs_cnt), 65'd1);
      check("idle_after", 65'(out_valid), 65'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
